// File: rtl/sram_1r1w_wmask.sv
// sram_1r1w_wmask: 1R1W SRAM model, per-byte write mask, read latency 1/2,
// write-first forwarding and a clear-on-reset sweep.
// Ports: clk0, rst (async, active-high); write port csb0/wmask0/addr0/din0;
// read port csb1/addr1 -> dout1/dout1_valid; ready high once memory is cleared.
module sram_1r1w_wmask #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int NUM_WMASKS   = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  ready
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST =
        ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  init_last;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;

    assign init_last = (state_q == INIT) && (init_cnt == LAST);
    assign wr_en     = (state_q == RUN) && !csb0;
    assign rd_en     = (state_q == RUN) && !csb1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: if (init_last) state_d = RUN;
            RUN:  state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == RUN);
            // Counter parks on the last address instead of wrapping.
            if (state_q == INIT && !init_last)
                init_cnt <= init_cnt + 1'b1;
        end
    end

    // Storage has no reset: it is cleared by the INIT sweep, one word
    // per edge, never asynchronously.
    always_ff @(posedge clk0) begin
        if (!rst) begin
            if (state_q == INIT) begin
                mem[init_cnt] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (wmask0[i])
                        mem[addr0][8*i +: 8] <= din0[8*i +: 8];
                end
            end
        end
    end

    // Write-first: enabled bytes of a same-edge write to the read
    // address override the stored bytes.
    always_comb begin
        rd_word = mem[addr1];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wr_en && addr0 == addr1 && wmask0[i])
                rd_word[8*i +: 8] = din0[8*i +: 8];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data;
        logic                  s1_valid;

        always_ff @(posedge clk0 or posedge rst) begin
            if (rst) begin
                s1_data     <= '0;
                s1_valid    <= 1'b0;
                dout1       <= '0;
                dout1_valid <= 1'b0;
            end else begin
                s1_valid    <= rd_en;
                dout1_valid <= s1_valid;
                if (rd_en)
                    s1_data <= rd_word;
                if (s1_valid)
                    dout1 <= s1_data;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk0 or posedge rst) begin
            if (rst) begin
                dout1       <= '0;
                dout1_valid <= 1'b0;
            end else begin
                dout1_valid <= rd_en;
                if (rd_en)
                    dout1 <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_sram_1r1w_wmask.sv
// tb_sram_1r1w_wmask: directed checks of sram_1r1w_wmask, with one
// instance at read latency 1 and one at latency 2 sharing all inputs.
module tb_sram_1r1w_wmask;

    logic        clk0;
    logic        rst;
    logic        csb0;
    logic [3:0]  wmask0;
    logic [9:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [9:0]  addr1;

    logic [31:0] d1_dout;
    logic        d1_valid;
    logic        d1_ready;
    logic [31:0] d2_dout;
    logic        d2_valid;
    logic        d2_ready;

    int total = 0;
    int bad   = 0;
    int n;
    int seen_v;

    sram_1r1w_wmask #(.READ_LATENCY(1)) u_dut1 (
        .clk0        (clk0),
        .rst         (rst),
        .csb0        (csb0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .csb1        (csb1),
        .addr1       (addr1),
        .dout1       (d1_dout),
        .dout1_valid (d1_valid),
        .ready       (d1_ready)
    );

    sram_1r1w_wmask #(.READ_LATENCY(2)) u_dut2 (
        .clk0        (clk0),
        .rst         (rst),
        .csb0        (csb0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .csb1        (csb1),
        .addr1       (addr1),
        .dout1       (d2_dout),
        .dout1_valid (d2_valid),
        .ready       (d2_ready)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    function automatic logic [31:0] pat(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic tick;
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Counts edges until ready rises; times out after 3000 edges.
    task automatic wait_ready(output int cnt, output int sv);
        cnt = 0;
        sv  = 0;
        while (!d1_ready && cnt < 3000) begin
            tick();
            cnt++;
            if (d1_valid || d2_valid)
                sv = 1;
        end
    endtask

    task automatic do_read(input string tag,
                           input logic [9:0] a,
                           input logic [31:0] exp);
        csb1  = 1'b0;
        addr1 = a;
        tick();
        chk({tag, "_l1_data"}, d1_dout, exp);
        chk({tag, "_l1_vld"}, 32'(d1_valid), 32'd1);
        csb1 = 1'b1;
        tick();
        chk({tag, "_l1_vld_off"}, 32'(d1_valid), 32'd0);
        chk({tag, "_l2_data"}, d2_dout, exp);
        chk({tag, "_l2_vld"}, 32'(d2_valid), 32'd1);
    endtask

    task automatic do_write(input logic [9:0] a,
                            input logic [31:0] d,
                            input logic [3:0] m);
        csb0   = 1'b0;
        addr0  = a;
        din0   = d;
        wmask0 = m;
        tick();
        csb0 = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        csb0   = 1'b1;
        csb1   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        addr1  = '0;
        tick();
        tick();
        chk("rst_ready", 32'(d1_ready), 32'd0);
        chk("rst_dout1", d1_dout, 32'd0);
        chk("rst_vld1", 32'(d1_valid), 32'd0);
        chk("rst_dout2", d2_dout, 32'd0);
        chk("rst_vld2", 32'(d2_valid), 32'd0);

        // Ports driven during INIT must be ignored.
        rst    = 1'b0;
        csb0   = 1'b0;
        addr0  = 10'd3;
        din0   = 32'hDEAD_BEEF;
        wmask0 = 4'hF;
        csb1   = 1'b0;
        addr1  = 10'd3;
        wait_ready(n, seen_v);
        csb0 = 1'b1;
        csb1 = 1'b1;
        chk("clear_edges", 32'(n), 32'd1024);
        chk("init_no_valid", 32'(seen_v), 32'd0);
        chk("ready_l2", 32'(d2_ready), 32'd1);

        do_read("init_gate_a3", 10'd3, 32'd0);
        do_read("clr_a0", 10'd0, 32'd0);
        do_read("clr_a1", 10'd1, 32'd0);
        do_read("clr_a1023", 10'd1023, 32'd0);

        do_write(10'd5, 32'hAABB_CCDD, 4'b1111);
        do_write(10'd5, 32'h1122_3344, 4'b0101);
        do_read("bmask_a5", 10'd5, 32'hAA22_CC44);

        do_write(10'd6, 32'h5555_5555, 4'b0000);
        do_read("nomask_a6", 10'd6, 32'd0);

        // Collision on address 9, then overwrite it while the
        // latency-2 result is still in flight.
        csb0   = 1'b0;
        addr0  = 10'd9;
        din0   = 32'hFFFF_FFFF;
        wmask0 = 4'b0011;
        csb1   = 1'b0;
        addr1  = 10'd9;
        tick();
        chk("coll_l1_data", d1_dout, 32'h0000_FFFF);
        chk("coll_l1_vld", 32'(d1_valid), 32'd1);
        csb1   = 1'b1;
        din0   = 32'h1234_5678;
        wmask0 = 4'hF;
        tick();
        csb0 = 1'b1;
        chk("coll_l2_data", d2_dout, 32'h0000_FFFF);
        chk("coll_l2_vld", 32'(d2_valid), 32'd1);
        chk("coll_l1_off", 32'(d1_valid), 32'd0);
        do_read("after_coll_a9", 10'd9, 32'h1234_5678);

        for (int i = 0; i < 8; i++)
            do_write(10'(i), pat(i), 4'hF);
        for (int i = 0; i < 8; i++) begin
            csb1  = 1'b0;
            addr1 = 10'(i);
            tick();
            chk($sformatf("str_l1_d%0d", i), d1_dout, pat(i));
            chk($sformatf("str_l1_v%0d", i), 32'(d1_valid), 32'd1);
            if (i > 0) begin
                chk($sformatf("str_l2_d%0d", i - 1), d2_dout, pat(i - 1));
                chk($sformatf("str_l2_v%0d", i - 1), 32'(d2_valid), 32'd1);
            end else begin
                chk("str_l2_v_pre", 32'(d2_valid), 32'd0);
            end
        end
        csb1 = 1'b1;
        tick();
        chk("str_l1_end_v", 32'(d1_valid), 32'd0);
        chk("str_l1_hold", d1_dout, pat(7));
        chk("str_l2_d7", d2_dout, pat(7));
        chk("str_l2_v7", 32'(d2_valid), 32'd1);
        tick();
        chk("str_l2_end_v", 32'(d2_valid), 32'd0);
        chk("str_l2_hold", d2_dout, pat(7));

        // Reset while reads are in flight.
        csb1  = 1'b0;
        addr1 = 10'd5;
        tick();
        chk("mid_l1_vld", 32'(d1_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_d1", d1_dout, 32'd0);
        chk("mid_rst_v1", 32'(d1_valid), 32'd0);
        chk("mid_rst_d2", d2_dout, 32'd0);
        chk("mid_rst_v2", 32'(d2_valid), 32'd0);
        chk("mid_rst_rdy", 32'(d1_ready), 32'd0);
        csb1 = 1'b1;
        tick();
        tick();
        chk("mid_rst_v2_drop", 32'(d2_valid), 32'd0);
        rst = 1'b0;
        wait_ready(n, seen_v);
        chk("reclear_edges", 32'(n), 32'd1024);
        chk("reclear_no_vld", 32'(seen_v), 32'd0);
        do_read("reclr_a5", 10'd5, 32'd0);
        do_read("reclr_a9", 10'd9, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
